// File: rtl/seq_pkg.sv
// Shared types and helpers for the phase sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } seq_state_t;

  // Widest dwell entry the helper accepts; dwell entries are zero-extended into it.
  localparam int DWELL_MAX_W = 16;

  // A programmed dwell of zero still occupies one cycle.
  function automatic logic [DWELL_MAX_W-1:0] dwell_eff(input logic [DWELL_MAX_W-1:0] d);
    return (d == '0) ? DWELL_MAX_W'(1) : d;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-phase cycle counter: clears on request, counts when enabled, and
// flags the last cycle of the current dwell.
module dwell_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,   // effective dwell, always >= 1
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_d, count_q;

  // Next count: clear wins over enable; otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CNT_W'(1);
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_2) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count  = count_q;
  assign expire = (count_q == limit - CNT_W'(1));

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase timed sequencer: walks NPHASES phases, each held for its
// dwell count, in cyclic or one-shot mode with start/stop/hold/skip.
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int NPHASES = 2,
  parameter int CNT_W   = 4,
  parameter logic [NPHASES-1:0][CNT_W-1:0] DWELL = {4'd3, 4'd4},
  localparam int PH_W = (NPHASES > 1) ? $clog2(NPHASES) : 1
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               skip,
  input  logic               oneshot,
  output logic [PH_W-1:0]    phase,
  output logic [NPHASES-1:0] phase_oh,
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               phase_start,
  output logic               wrap,
  output logic               done
);

  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NPHASES - 1);

  seq_state_t         state_d, state_q;
  logic [PH_W-1:0]    phase_d, phase_q;
  logic [NPHASES-1:0] phase_oh_d, phase_oh_q;
  logic               mode_d, mode_q;          // 1 = one-shot
  logic               busy_d, busy_q;
  logic               phase_start_d, phase_start_q;
  logic               wrap_d, wrap_q;
  logic               done_d, done_q;

  logic               tmr_clr, tmr_en, tmr_expire;
  logic [CNT_W-1:0]   dwell_cur;

  assign dwell_cur = CNT_W'(dwell_eff(DWELL_MAX_W'(DWELL[phase_q])));

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_2  (clk_2),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .limit  (dwell_cur),
    .count  (count),
    .expire (tmr_expire)
  );

  // Next state and next registered outputs; priority stop > start > hold > skip/expiry.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    mode_d        = mode_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;
    phase_start_d = 1'b0;
    wrap_d        = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      phase_d = '0;
      tmr_clr = 1'b1;
    end else if (start) begin
      state_d       = S_RUN;
      phase_d       = '0;
      mode_d        = oneshot;
      tmr_clr       = 1'b1;
      phase_start_d = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          if (hold) begin
            state_d = S_HOLD;
          end else if (tmr_expire || skip) begin
            tmr_clr = 1'b1;
            if (phase_q != LAST_PHASE) begin
              phase_d       = phase_q + PH_W'(1);
              phase_start_d = 1'b1;
            end else if (mode_q) begin
              state_d = S_DONE;
            end else begin
              phase_d       = '0;
              phase_start_d = 1'b1;
              wrap_d        = 1'b1;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
        S_HOLD: begin
          if (!hold) state_d = S_RUN;
        end
        default: ;
      endcase
    end

    busy_d     = (state_d == S_RUN) || (state_d == S_HOLD);
    done_d     = (state_d == S_DONE);
    phase_oh_d = (state_d == S_IDLE) ? '0 : (NPHASES'(1) << phase_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      phase_oh_q    <= '0;
      mode_q        <= 1'b0;
      busy_q        <= 1'b0;
      phase_start_q <= 1'b0;
      wrap_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_oh_q    <= phase_oh_d;
      mode_q        <= mode_d;
      busy_q        <= busy_d;
      phase_start_q <= phase_start_d;
      wrap_q        <= wrap_d;
      done_q        <= done_d;
    end
  end

  assign phase       = phase_q;
  assign phase_oh    = phase_oh_q;
  assign busy        = busy_q;
  assign phase_start = phase_start_q;
  assign wrap        = wrap_q;
  assign done        = done_q;

endmodule
